imm_gen_pipe: RTL and testbench

Parametrised, registered immediate generator for the RISC-V pipeline decode stage. It extracts and sign- or zero-extends the immediate from a 32-bit instruction word to XLEN bits for all base formats plus CSR-immediate and shift-amount formats. Each result carries a sideband tag, and the block exposes a valid/ready handshake with a 2-entry skid buffer. It sits between instruction fetch/decode and the ID/EX register, giving 1-cycle latency at full throughput under backpressure.

---
 rtl/imm_gen_pipe.sv | 111 +++++++++++
 tb/tb_imm_gen_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a 2-entry skid buffer.
// Optional IMM_GEN_SEL_CHECK_EN stores an illegal-select flag that is driven on out_err.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  imm_d;
    logic             accept, drain;
    logic             o_valid_q, s_valid_q;
    logic [XLEN-1:0]  o_imm_q, s_imm_q;
    logic [TAG_W-1:0] o_tag_q, s_tag_q;
    logic             unused_opcode;

    // The opcode field never contributes to any immediate.
    assign unused_opcode = ^in_inst[6:0];

    always_comb begin
        imm_d = '0;
        case (in_sel)
            3'b000: imm_d = XLEN'($signed(in_inst[31:20]));
            3'b001: imm_d = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            3'b010: imm_d = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
            3'b011: imm_d = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
            3'b100: imm_d = XLEN'($signed({in_inst[31:12], 12'b0}));
            3'b101: imm_d = XLEN'(in_inst[19:15]);
            3'b110: imm_d = XLEN'(in_inst[20 +: SHW]);
            default: imm_d = '0;
        endcase
    end

    assign in_ready  = !s_valid_q && !rst;
    assign accept    = in_valid && in_ready;
    assign drain     = o_valid_q && out_ready;
    assign out_valid = o_valid_q;
    assign out_imm   = o_imm_q;
    assign out_tag   = o_tag_q;

`ifdef IMM_GEN_SEL_CHECK_EN
    logic err_d, o_err_q, s_err_q;
    assign err_d   = &in_sel;
    assign out_err = o_err_q;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            o_imm_q   <= '0;
            o_tag_q   <= '0;
            s_imm_q   <= '0;
            s_tag_q   <= '0;
`ifdef IMM_GEN_SEL_CHECK_EN
            o_err_q   <= 1'b0;
            s_err_q   <= 1'b0;
`endif
        end else if (flush) begin
            o_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else if (s_valid_q) begin
            // S non-empty blocks input, so only the S->O shift can happen here.
            if (drain) begin
                o_imm_q   <= s_imm_q;
                o_tag_q   <= s_tag_q;
                s_valid_q <= 1'b0;
`ifdef IMM_GEN_SEL_CHECK_EN
                o_err_q   <= s_err_q;
`endif
            end
        end else if (accept) begin
            if (!o_valid_q || drain) begin
                o_valid_q <= 1'b1;
                o_imm_q   <= imm_d;
                o_tag_q   <= in_tag;
`ifdef IMM_GEN_SEL_CHECK_EN
                o_err_q   <= err_d;
`endif
            end else begin
                s_valid_q <= 1'b1;
                s_imm_q   <= imm_d;
                s_tag_q   <= in_tag;
`ifdef IMM_GEN_SEL_CHECK_EN
                s_err_q   <= err_d;
`endif
            end
        end else if (drain) begin
            o_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe (XLEN=32), covering decode, handshake, flush and reset.
module tb_imm_gen_pipe;
    localparam int XLEN  = 32;
    localparam int TAG_W = 32;
    localparam int NT    = 14;
`ifdef IMM_GEN_SEL_CHECK_EN
    localparam logic EC = 1'b1;
`else
    localparam logic EC = 1'b0;
`endif
    // {inst, sel, expected imm, expected err}
    localparam logic [67:0] TBL [NT] = '{
        {32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0},
        {32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0},
        {32'h123450B7, 3'd4, 32'h12345000, 1'b0},
        {32'h000FD073, 3'd5, 32'h0000001F, 1'b0},
        {32'h7FF00013, 3'd0, 32'h000007FF, 1'b0},
        {32'hFE000E23, 3'd1, 32'hFFFFFFFC, 1'b0},
        {32'h00A12223, 3'd1, 32'h00000004, 1'b0},
        {32'h00000463, 3'd2, 32'h00000008, 1'b0},
        {32'h0080006F, 3'd3, 32'h00000008, 1'b0},
        {32'hFFDFF06F, 3'd3, 32'hFFFFFFFC, 1'b0},
        {32'hFFFFF037, 3'd4, 32'hFFFFF000, 1'b0},
        {32'h8000D073, 3'd5, 32'h00000001, 1'b0},
        {32'h41F0D093, 3'd6, 32'h0000001F, 1'b0},
        {32'hFFFFFFFF, 3'd7, 32'h00000000, EC}
    };

    logic             clk, rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0]      in_inst;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN+TAG_W:0] sb[$];
    logic [67:0]      r;
    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_inst = '0; in_sel = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_imm, out_tag, out_err} !== '0) begin
            errors++; $display("FAIL reset_out: valid=%b imm=%h tag=%h err=%b expected all zero", out_valid, out_imm, out_tag, out_err);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: in_ready=%b expected 0", in_ready); end
        rst = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: in_ready=%b expected 1", in_ready); end
    endtask

    task automatic test_formats();
        int k = 0;
        out_ready = 1;
        for (int c = 0; c < 40 && (k < NT || sb.size() != 0); c++) begin
            in_valid = (k < NT);
            r = TBL[k % NT];
            in_inst = r[67:36]; in_sel = r[35:33]; in_tag = 32'hA000_0000 + k;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL fmt_ready: in_ready=%b expected 1", in_ready); end
            checks++;
            if (out_valid !== (sb.size() != 0)) begin errors++; $display("FAIL fmt_valid: out_valid=%b expected %b", out_valid, sb.size() != 0); end
            if (sb.size() != 0) begin
                checks++;
                if ({out_imm, out_tag, out_err} !== sb[0]) begin
                    errors++; $display("FAIL fmt_data: imm=%h tag=%h err=%b expected {imm,tag,err}=%h", out_imm, out_tag, out_err, sb[0]);
                end
                if (out_valid && out_ready) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin sb.push_back({r[32:1], in_tag, r[0]}); k++; end
            @(posedge clk); #1;
        end
        in_valid = 0;
        checks++;
        if (k != NT || sb.size() != 0) begin errors++; $display("FAIL fmt_done: sent=%0d pending=%0d expected %0d/0", k, sb.size(), NT); end
    endtask

    task automatic test_illegal();
        out_ready = 1; in_valid = 1; in_inst = 32'hFFFFFFFF; in_sel = 3'd7; in_tag = 32'h0000_00C0;
        @(posedge clk); #1;
        in_inst = 32'hFFF00093; in_sel = 3'd0; in_tag = 32'h0000_00C1;
        checks++;
        if ({out_valid, out_imm, out_err} !== {1'b1, 32'h0, EC}) begin
            errors++; $display("FAIL illegal_sel: valid=%b imm=%h err=%b expected 1/0/%b", out_valid, out_imm, out_err, EC);
        end
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if ({out_valid, out_imm, out_tag, out_err} !== {1'b1, 32'hFFFFFFFF, 32'h0000_00C1, 1'b0}) begin
            errors++; $display("FAIL illegal_next: valid=%b imm=%h tag=%h err=%b expected 1/ffffffff/000000c1/0", out_valid, out_imm, out_tag, out_err);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_drain: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        for (int c = 0; c < 40 && (k < 4 || sb.size() != 0); c++) begin
            out_ready = (c >= 6);
            in_valid = (k < 4);
            r = TBL[(k + 4) % NT];
            in_inst = r[67:36]; in_sel = r[35:33]; in_tag = 32'hB000_0000 + k;
            if (c >= 2 && c < 6) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: cycle %0d in_ready=%b expected 0", c, in_ready); end
            end
            checks++;
            if (out_valid !== (sb.size() != 0)) begin errors++; $display("FAIL bp_valid: out_valid=%b expected %b", out_valid, sb.size() != 0); end
            if (sb.size() != 0) begin
                checks++;
                if ({out_imm, out_tag, out_err} !== sb[0]) begin
                    errors++; $display("FAIL bp_data: imm=%h tag=%h err=%b expected {imm,tag,err}=%h", out_imm, out_tag, out_err, sb[0]);
                end
                if (out_valid && out_ready) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin sb.push_back({r[32:1], in_tag, r[0]}); k++; end
            @(posedge clk); #1;
        end
        in_valid = 0;
        checks++;
        if (k != 4 || sb.size() != 0) begin errors++; $display("FAIL bp_done: sent=%0d pending=%0d expected 4/0", k, sb.size()); end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 2; i++) begin
            r = TBL[i]; in_inst = r[67:36]; in_sel = r[35:33]; in_tag = 32'hD000_0000 + i;
            @(posedge clk); #1;
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL flush_full: valid=%b ready=%b expected 1/0", out_valid, in_ready); end
        flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_both: valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        in_valid = 1; r = TBL[2]; in_inst = r[67:36]; in_sel = r[35:33]; in_tag = 32'hD000_0002;
        @(posedge clk); #1;
        in_tag = 32'hD000_0003;
        flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: out_valid=%b tag=%h expected 0", out_valid, out_tag); end
            @(posedge clk); #1;
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int k = 0;
        for (int c = 0; c < 400 && (c < 120 || sb.size() != 0); c++) begin
            in_valid = (c < 120) && ($urandom_range(9) < 7);
            out_ready = (c >= 120) || ($urandom_range(9) < 6);
            r = TBL[k % NT];
            in_inst = r[67:36]; in_sel = r[35:33]; in_tag = $urandom;
            checks++;
            if (out_valid !== (sb.size() != 0)) begin errors++; $display("FAIL b2b_valid: out_valid=%b expected %b", out_valid, sb.size() != 0); end
            if (sb.size() != 0) begin
                checks++;
                if ({out_imm, out_tag, out_err} !== sb[0]) begin
                    errors++; $display("FAIL b2b_data: imm=%h tag=%h err=%b expected {imm,tag,err}=%h", out_imm, out_tag, out_err, sb[0]);
                end
                if (out_valid && out_ready) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin sb.push_back({r[32:1], in_tag, r[0]}); k++; end
            @(posedge clk); #1;
        end
        in_valid = 0;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_done: pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; in_inst = 32'hFFF00093; in_sel = 3'd0; in_tag = 32'hE000_0001;
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: out_valid=%b expected 1", out_valid); end
        rst = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: in_ready=%b expected 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_imm, out_tag, in_ready} !== '0) begin
            errors++; $display("FAIL rstmid_out: valid=%b imm=%h tag=%h ready=%b expected all zero", out_valid, out_imm, out_tag, in_ready);
        end
        rst = 0; out_ready = 1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL rstmid_release: ready=%b valid=%b expected 1/0", in_ready, out_valid); end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_formats();
        test_illegal();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end
endmodule
